// File: rtl/buart_txq_pkg.sv
// Shared constants and types for the buart transmit queue.
// Holds the default queue depth and the pacer state encoding.
package buart_txq_pkg;

  localparam int CFG_TXQ_DEPTH = 16;

  typedef enum logic [1:0] {
    PACE_IDLE   = 2'd0,
    PACE_STROBE = 2'd1,
    PACE_SETTLE = 2'd2
  } pace_state_e;

endpackage

// File: rtl/buart_txq_byte_fifo.sv
// Power-of-two byte FIFO with an explicit level counter.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module buart_txq_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          drop
);

  localparam logic [AW:0]   LEVEL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;

  assign full    = (level == LEVEL_MAX);
  assign empty   = (level == '0);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and level define valid contents.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/buart_txq.sv
// Transmit byte queue feeding the buart wr/tx_data strobe interface.
// Buffers CPU writes and paces them onto the UART using its busy flag.
module buart_txq
  import buart_txq_pkg::*;
#(
  parameter int DEPTH = CFG_TXQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        push,
  input  logic [7:0]  push_data,
  input  logic        ovf_clr,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic        overflow,
  output logic        uart_wr,
  output logic [7:0]  uart_data,
  input  logic        uart_busy,
  output pace_state_e state
);

  // Handshakes: push is fire-and-forget (dropped and flagged when full with no
  // pop); uart_wr is a one-cycle strobe issued only from IDLE with busy low,
  // and uart_data is held stable from that strobe until the next one.

  pace_state_e state_next;
  logic        pop;
  logic        drop;
  logic [7:0]  rd_data;

  buart_txq_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .resetq    (resetq),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .drop      (drop)
  );

  // The entry is consumed while its strobe is on the wire.
  assign pop = (state == PACE_STROBE);

  always_comb begin
    state_next = state;
    case (state)
      PACE_IDLE:   if (!empty && !uart_busy) state_next = PACE_STROBE;
      PACE_STROBE: state_next = PACE_SETTLE;
      // buart raises busy one cycle after wr, so busy is not trusted here.
      PACE_SETTLE: state_next = PACE_IDLE;
      default:     state_next = PACE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state     <= PACE_IDLE;
      uart_wr   <= 1'b0;
      uart_data <= 8'h00;
    end else begin
      state   <= state_next;
      uart_wr <= (state_next == PACE_STROBE);
      if (state == PACE_IDLE && state_next == PACE_STROBE) begin
        uart_data <= rd_data;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_buart_txq.sv
// Directed bench for buart_txq with a small buart busy model.
// Sent bytes are collected by a monitor and compared against an expected queue.
module tb_buart_txq;
  import buart_txq_pkg::*;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int DIVIDER  = 2;
  localparam int BUSY_LEN = 10 * DIVIDER;

  logic        clk;
  logic        resetq;
  logic        push;
  logic [7:0]  push_data;
  logic        ovf_clr;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        uart_wr;
  logic [7:0]  uart_data;
  logic        uart_busy;
  pace_state_e state;

  logic        model_en;
  logic        man_busy;
  int          busy_cnt;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          viol_cnt;

  int          pass_cnt;
  int          total_cnt;
  int          fail_cnt;

  buart_txq #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetq    (resetq),
    .push      (push),
    .push_data (push_data),
    .ovf_clr   (ovf_clr),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .uart_wr   (uart_wr),
    .uart_data (uart_data),
    .uart_busy (uart_busy),
    .state     (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buart model: busy rises the edge after wr is seen, lasts one frame.
  assign uart_busy = model_en ? (busy_cnt != 0) : man_busy;

  always @(posedge clk) begin
    if (uart_wr) begin
      busy_cnt <= BUSY_LEN;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Monitor: capture each strobe, flag any strobe issued while busy.
  always @(posedge clk) begin
    if (uart_wr) begin
      got_q.push_back(uart_data);
      if (uart_busy) viol_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    pass_cnt  = 0;
    total_cnt = 0;
    fail_cnt  = 0;
    viol_cnt  = 0;
    busy_cnt  = 0;
    model_en  = 1'b0;
    man_busy  = 1'b1;
    push      = 1'b0;
    push_data = 8'h00;
    ovf_clr   = 1'b0;
    resetq    = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_uart_wr", 32'(uart_wr), 32'd0);
    check("rst_uart_data", 32'(uart_data), 32'h00);
    check("rst_state", 32'(state), 32'(PACE_IDLE));
    resetq = 1'b1;
    tick();
    // busy high at power-up holds the pacer idle
    check("busy_hold_idle", 32'(state), 32'(PACE_IDLE));

    // Single byte: strobe one cycle after level becomes 1
    man_busy  = 1'b0;
    push      = 1'b1;
    push_data = 8'h41;
    tick();
    push = 1'b0;
    check("one_level_after_push", 32'(level), 32'd1);
    check("one_wr_not_yet", 32'(uart_wr), 32'd0);
    tick();
    check("one_wr_pulse", 32'(uart_wr), 32'd1);
    check("one_wr_data", 32'(uart_data), 32'h41);
    tick();
    check("one_wr_fall", 32'(uart_wr), 32'd0);
    check("one_level_zero", 32'(level), 32'd0);
    check("one_empty", 32'(empty), 32'd1);
    repeat (6) tick();
    check("one_pulse_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("one_pulse_byte", 32'(got_q[0]), 32'h41);
    got_q.delete();

    // Fill to full with busy held high
    man_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      push      = 1'b1;
      push_data = 8'h10 + 8'(i);
      exp_q.push_back(push_data);
      tick();
    end
    push = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    check("fill_overflow_clear", 32'(overflow), 32'd0);

    // Drop while full, clear, then clear racing a drop
    push      = 1'b1;
    push_data = 8'hEE;
    tick();
    push = 1'b0;
    check("drop_level", 32'(level), 32'd16);
    check("drop_overflow", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    check("clr_overflow", 32'(overflow), 32'd0);
    push      = 1'b1;
    push_data = 8'hEE;
    tick();
    push = 1'b0;
    check("clr_vs_drop", 32'(overflow), 32'd1);
    tick();
    ovf_clr = 1'b0;
    check("clr_again", 32'(overflow), 32'd0);
    check("drop_level_kept", 32'(level), 32'd16);

    // Drain through the buart model; push 8'h55 during the first strobe
    model_en = 1'b1;
    n = 0;
    while (uart_wr !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("drain_first_wr", 32'(uart_wr), 32'd1);
    push      = 1'b1;
    push_data = 8'h55;
    exp_q.push_back(8'h55);
    tick();
    push = 1'b0;
    check("strobe_push_level", 32'(level), 32'd16);
    check("strobe_push_overflow", 32'(overflow), 32'd0);
    n = 0;
    while (got_q.size() < 17 && n < 3000) begin
      tick();
      n++;
    end
    repeat (2 * BUSY_LEN) tick();
    check("drain_count", 32'(got_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      if (i < got_q.size()) check($sformatf("drain_order[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_overflow", 32'(overflow), 32'd0);
    check("busy_lag_no_early_wr", 32'(viol_cnt), 32'd0);
    got_q.delete();
    exp_q.delete();

    // Asynchronous reset during STROBE with 5 entries queued
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push      = 1'b1;
      push_data = 8'hA0 + 8'(i);
      tick();
    end
    push = 1'b0;
    check("rst5_level", 32'(level), 32'd5);
    man_busy = 1'b0;
    n = 0;
    while (uart_wr !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("rst5_in_strobe", 32'(state), 32'(PACE_STROBE));
    #2;
    resetq = 1'b0;
    #1;
    check("rst5_wr_low", 32'(uart_wr), 32'd0);
    check("rst5_level_zero", 32'(level), 32'd0);
    check("rst5_empty", 32'(empty), 32'd1);
    got_q.delete();
    tick();
    #2;
    resetq = 1'b1;
    repeat (12) tick();
    check("rst5_no_stale", 32'(got_q.size()), 32'd0);
    check("rst5_state_idle", 32'(state), 32'(PACE_IDLE));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
